// File: rtl/rv32i_pkg.sv
// Shared RV32I encoding constants, operation ids, immediate formats and op decode table.
package rv32i_pkg;

  // Major opcodes.
  localparam logic [6:0] OpcOp     = 7'h33;
  localparam logic [6:0] OpcOpImm  = 7'h13;
  localparam logic [6:0] OpcLoad   = 7'h03;
  localparam logic [6:0] OpcStore  = 7'h23;
  localparam logic [6:0] OpcBranch = 7'h63;
  localparam logic [6:0] OpcJal    = 7'h6F;
  localparam logic [6:0] OpcJalr   = 7'h67;
  localparam logic [6:0] OpcLui    = 7'h37;
  localparam logic [6:0] OpcAuipc  = 7'h17;

  // ALU funct3.
  localparam logic [2:0] F3AddSub = 3'd0;
  localparam logic [2:0] F3Sll    = 3'd1;
  localparam logic [2:0] F3Slt    = 3'd2;
  localparam logic [2:0] F3Sltu   = 3'd3;
  localparam logic [2:0] F3Xor    = 3'd4;
  localparam logic [2:0] F3SrlSra = 3'd5;
  localparam logic [2:0] F3Or     = 3'd6;
  localparam logic [2:0] F3And    = 3'd7;

  // Branch funct3.
  localparam logic [2:0] F3Beq  = 3'd0;
  localparam logic [2:0] F3Bne  = 3'd1;
  localparam logic [2:0] F3Blt  = 3'd4;
  localparam logic [2:0] F3Bge  = 3'd5;
  localparam logic [2:0] F3Bltu = 3'd6;
  localparam logic [2:0] F3Bgeu = 3'd7;

  // Load/store width funct3.
  localparam logic [2:0] F3Byte  = 3'd0;
  localparam logic [2:0] F3Half  = 3'd1;
  localparam logic [2:0] F3Word  = 3'd2;
  localparam logic [2:0] F3ByteU = 3'd4;
  localparam logic [2:0] F3HalfU = 3'd5;

  localparam logic [6:0] F7Base = 7'h00;
  localparam logic [6:0] F7Alt  = 7'h20;

  // Operation ids as presented on in_op.
  localparam logic [5:0] OpLui   = 6'd0;
  localparam logic [5:0] OpAuipc = 6'd1;
  localparam logic [5:0] OpJal   = 6'd2;
  localparam logic [5:0] OpJalr  = 6'd3;
  localparam logic [5:0] OpBeq   = 6'd4;
  localparam logic [5:0] OpBne   = 6'd5;
  localparam logic [5:0] OpBlt   = 6'd6;
  localparam logic [5:0] OpBge   = 6'd7;
  localparam logic [5:0] OpBltu  = 6'd8;
  localparam logic [5:0] OpBgeu  = 6'd9;
  localparam logic [5:0] OpLb    = 6'd10;
  localparam logic [5:0] OpLh    = 6'd11;
  localparam logic [5:0] OpLw    = 6'd12;
  localparam logic [5:0] OpLbu   = 6'd13;
  localparam logic [5:0] OpLhu   = 6'd14;
  localparam logic [5:0] OpSb    = 6'd15;
  localparam logic [5:0] OpSh    = 6'd16;
  localparam logic [5:0] OpSw    = 6'd17;
  localparam logic [5:0] OpAddi  = 6'd18;
  localparam logic [5:0] OpSlti  = 6'd19;
  localparam logic [5:0] OpSltiu = 6'd20;
  localparam logic [5:0] OpXori  = 6'd21;
  localparam logic [5:0] OpOri   = 6'd22;
  localparam logic [5:0] OpAndi  = 6'd23;
  localparam logic [5:0] OpSlli  = 6'd24;
  localparam logic [5:0] OpSrli  = 6'd25;
  localparam logic [5:0] OpSrai  = 6'd26;
  localparam logic [5:0] OpAdd   = 6'd27;
  localparam logic [5:0] OpSub   = 6'd28;
  localparam logic [5:0] OpSll   = 6'd29;
  localparam logic [5:0] OpSlt   = 6'd30;
  localparam logic [5:0] OpSltu  = 6'd31;
  localparam logic [5:0] OpXor   = 6'd32;
  localparam logic [5:0] OpSrl   = 6'd33;
  localparam logic [5:0] OpSra   = 6'd34;
  localparam logic [5:0] OpOr    = 6'd35;
  localparam logic [5:0] OpAnd   = 6'd36;

  // ADDI x0, x0, 0: emitted in place of any rejected request.
  localparam logic [31:0] NopWord = 32'h0000_0013;

  // FmtR carries no immediate; the rest mirror the ISA immediate formats.
  typedef enum logic [2:0] {FmtR, FmtI, FmtS, FmtB, FmtU, FmtJ} fmt_e;

  typedef struct packed {
    logic       legal;
    fmt_e       fmt;
    logic       shamt;   // I-format whose immediate is a 5-bit shift amount
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
  } op_info_t;

  function automatic op_info_t op_decode(input logic [5:0] op);
    op_info_t info;
    info = '{legal: 1'b1, fmt: FmtR, shamt: 1'b0, opcode: OpcOp, funct3: F3AddSub,
             funct7: F7Base};
    case (op)
      OpLui:   begin info.fmt = FmtU; info.opcode = OpcLui;   end
      OpAuipc: begin info.fmt = FmtU; info.opcode = OpcAuipc; end
      OpJal:   begin info.fmt = FmtJ; info.opcode = OpcJal;   end
      OpJalr:  begin info.fmt = FmtI; info.opcode = OpcJalr;  end
      OpBeq:   begin info.fmt = FmtB; info.opcode = OpcBranch; info.funct3 = F3Beq;  end
      OpBne:   begin info.fmt = FmtB; info.opcode = OpcBranch; info.funct3 = F3Bne;  end
      OpBlt:   begin info.fmt = FmtB; info.opcode = OpcBranch; info.funct3 = F3Blt;  end
      OpBge:   begin info.fmt = FmtB; info.opcode = OpcBranch; info.funct3 = F3Bge;  end
      OpBltu:  begin info.fmt = FmtB; info.opcode = OpcBranch; info.funct3 = F3Bltu; end
      OpBgeu:  begin info.fmt = FmtB; info.opcode = OpcBranch; info.funct3 = F3Bgeu; end
      OpLb:    begin info.fmt = FmtI; info.opcode = OpcLoad; info.funct3 = F3Byte;  end
      OpLh:    begin info.fmt = FmtI; info.opcode = OpcLoad; info.funct3 = F3Half;  end
      OpLw:    begin info.fmt = FmtI; info.opcode = OpcLoad; info.funct3 = F3Word;  end
      OpLbu:   begin info.fmt = FmtI; info.opcode = OpcLoad; info.funct3 = F3ByteU; end
      OpLhu:   begin info.fmt = FmtI; info.opcode = OpcLoad; info.funct3 = F3HalfU; end
      OpSb:    begin info.fmt = FmtS; info.opcode = OpcStore; info.funct3 = F3Byte; end
      OpSh:    begin info.fmt = FmtS; info.opcode = OpcStore; info.funct3 = F3Half; end
      OpSw:    begin info.fmt = FmtS; info.opcode = OpcStore; info.funct3 = F3Word; end
      OpAddi:  begin info.fmt = FmtI; info.opcode = OpcOpImm; info.funct3 = F3AddSub; end
      OpSlti:  begin info.fmt = FmtI; info.opcode = OpcOpImm; info.funct3 = F3Slt;    end
      OpSltiu: begin info.fmt = FmtI; info.opcode = OpcOpImm; info.funct3 = F3Sltu;   end
      OpXori:  begin info.fmt = FmtI; info.opcode = OpcOpImm; info.funct3 = F3Xor;    end
      OpOri:   begin info.fmt = FmtI; info.opcode = OpcOpImm; info.funct3 = F3Or;     end
      OpAndi:  begin info.fmt = FmtI; info.opcode = OpcOpImm; info.funct3 = F3And;    end
      OpSlli:  begin
        info.fmt = FmtI; info.opcode = OpcOpImm; info.funct3 = F3Sll; info.shamt = 1'b1;
      end
      OpSrli:  begin
        info.fmt = FmtI; info.opcode = OpcOpImm; info.funct3 = F3SrlSra; info.shamt = 1'b1;
      end
      OpSrai:  begin
        info.fmt = FmtI; info.opcode = OpcOpImm; info.funct3 = F3SrlSra; info.shamt = 1'b1;
        info.funct7 = F7Alt;
      end
      OpAdd:   info.funct3 = F3AddSub;
      OpSub:   begin info.funct3 = F3AddSub; info.funct7 = F7Alt; end
      OpSll:   info.funct3 = F3Sll;
      OpSlt:   info.funct3 = F3Slt;
      OpSltu:  info.funct3 = F3Sltu;
      OpXor:   info.funct3 = F3Xor;
      OpSrl:   info.funct3 = F3SrlSra;
      OpSra:   begin info.funct3 = F3SrlSra; info.funct7 = F7Alt; end
      OpOr:    info.funct3 = F3Or;
      OpAnd:   info.funct3 = F3And;
      default: info.legal = 1'b0;
    endcase
    return info;
  endfunction

endpackage

// File: rtl/rv32i_imm_pack.sv
// Combinational op decode plus immediate packing: the inverse of an immediate generator.
// imm_word_o holds the immediate bits already placed at their instruction positions.
module rv32i_imm_pack
  import rv32i_pkg::*;
(
  input  logic [5:0]  op_i,
  input  logic [31:0] imm_i,
  output fmt_e        fmt_o,
  output logic [6:0]  opcode_o,
  output logic [2:0]  funct3_o,
  output logic [6:0]  funct7_o,
  output logic        legal_o,
  output logic        range_ok_o,
  output logic [31:0] imm_word_o
);

  op_info_t info;

  assign info     = op_decode(op_i);
  assign fmt_o    = info.fmt;
  assign opcode_o = info.opcode;
  assign funct3_o = info.funct3;
  assign funct7_o = info.funct7;
  assign legal_o  = info.legal;

  // Range check and bit scatter per immediate format.
  always_comb begin
    range_ok_o = 1'b1;
    imm_word_o = '0;
    case (info.fmt)
      FmtI: begin
        if (info.shamt) begin
          // Shift-immediates carry funct7 in the upper immediate bits.
          range_ok_o = (imm_i[31:5] == '0);
          imm_word_o = {info.funct7, imm_i[4:0], 20'b0};
        end else begin
          range_ok_o = (imm_i[31:12] == {20{imm_i[11]}});
          imm_word_o = {imm_i[11:0], 20'b0};
        end
      end
      FmtS: begin
        range_ok_o = (imm_i[31:12] == {20{imm_i[11]}});
        imm_word_o = {imm_i[11:5], 13'b0, imm_i[4:0], 7'b0};
      end
      FmtB: begin
        range_ok_o = (imm_i[31:13] == {19{imm_i[12]}}) && !imm_i[0];
        imm_word_o = {imm_i[12], imm_i[10:5], 13'b0, imm_i[4:1], imm_i[11], 7'b0};
      end
      FmtU: begin
        range_ok_o = (imm_i[11:0] == '0);
        imm_word_o = {imm_i[31:12], 12'b0};
      end
      FmtJ: begin
        range_ok_o = (imm_i[31:21] == {11{imm_i[20]}}) && !imm_i[0];
        imm_word_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], 12'b0};
      end
      default: begin
        range_ok_o = 1'b1;
        imm_word_o = '0;
      end
    endcase
  end

endmodule

// File: rtl/rv32i_instr_encoder.sv
// Symbolic RV32I request -> encoded instruction word and IMEM byte address.
// Two-stage valid/ready pipeline: stage 1 holds the decoded request, stage 2 the output word.
module rv32i_instr_encoder
  import rv32i_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic              out_last
);

  // Decode of the incoming request.
  fmt_e        dec_fmt;
  logic [6:0]  dec_opcode;
  logic [2:0]  dec_funct3;
  logic [6:0]  dec_funct7;
  logic        dec_legal;
  logic        dec_range_ok;
  logic [31:0] dec_imm_word;

  rv32i_imm_pack u_imm_pack (
    .op_i       (in_op),
    .imm_i      (in_imm),
    .fmt_o      (dec_fmt),
    .opcode_o   (dec_opcode),
    .funct3_o   (dec_funct3),
    .funct7_o   (dec_funct7),
    .legal_o    (dec_legal),
    .range_ok_o (dec_range_ok),
    .imm_word_o (dec_imm_word)
  );

  // Stage 1 state.
  logic        s1_valid_q, s1_valid_d;
  fmt_e        s1_fmt_q, s1_fmt_d;
  logic [6:0]  s1_opcode_q, s1_opcode_d;
  logic [2:0]  s1_funct3_q, s1_funct3_d;
  logic [6:0]  s1_funct7_q, s1_funct7_d;
  logic        s1_ok_q, s1_ok_d;
  logic [31:0] s1_imm_word_q, s1_imm_word_d;
  logic [4:0]  s1_rd_q, s1_rd_d;
  logic [4:0]  s1_rs1_q, s1_rs1_d;
  logic [4:0]  s1_rs2_q, s1_rs2_d;
  logic        s1_last_q, s1_last_d;

  // Stage 2 state and address counter.
  logic              s2_valid_q, s2_valid_d;
  logic [31:0]       s2_instr_q, s2_instr_d;
  logic [ADDR_W-1:0] s2_addr_q, s2_addr_d;
  logic              s2_err_q, s2_err_d;
  logic              s2_last_q, s2_last_d;
  logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;

  logic        s2_adv;
  logic        s1_adv;
  logic        s1_load;
  logic [31:0] asm_word;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = s1_valid_q && s2_adv;
  assign in_ready = !s1_valid_q || s2_adv;
  assign s1_load  = in_valid && in_ready;

  assign out_valid = s2_valid_q;
  assign out_instr = s2_instr_q;
  assign out_addr  = s2_addr_q;
  assign out_err   = s2_err_q;
  assign out_last  = s2_last_q;

  // Field assembly from the stage-1 request; only fields used by the format are inserted.
  always_comb begin
    asm_word = s1_imm_word_q | {25'b0, s1_opcode_q};
    case (s1_fmt_q)
      FmtR: asm_word = asm_word | {s1_funct7_q, s1_rs2_q, s1_rs1_q, s1_funct3_q, s1_rd_q, 7'b0};
      FmtI: asm_word = asm_word | {12'b0, s1_rs1_q, s1_funct3_q, s1_rd_q, 7'b0};
      FmtS,
      FmtB: asm_word = asm_word | {7'b0, s1_rs2_q, s1_rs1_q, s1_funct3_q, 12'b0};
      FmtU,
      FmtJ: asm_word = asm_word | {20'b0, s1_rd_q, 7'b0};
      default: asm_word = asm_word;
    endcase
    if (!s1_ok_q) begin
      asm_word = NopWord;
    end
  end

  // Next-state for both pipeline stages and the address counter.
  always_comb begin
    s1_valid_d    = s1_valid_q;
    s1_fmt_d      = s1_fmt_q;
    s1_opcode_d   = s1_opcode_q;
    s1_funct3_d   = s1_funct3_q;
    s1_funct7_d   = s1_funct7_q;
    s1_ok_d       = s1_ok_q;
    s1_imm_word_d = s1_imm_word_q;
    s1_rd_d       = s1_rd_q;
    s1_rs1_d      = s1_rs1_q;
    s1_rs2_d      = s1_rs2_q;
    s1_last_d     = s1_last_q;
    s2_valid_d    = s2_valid_q;
    s2_instr_d    = s2_instr_q;
    s2_addr_d     = s2_addr_q;
    s2_err_d      = s2_err_q;
    s2_last_d     = s2_last_q;
    addr_cnt_d    = addr_cnt_q;

    if (s1_load) begin
      s1_valid_d    = 1'b1;
      s1_fmt_d      = dec_fmt;
      s1_opcode_d   = dec_opcode;
      s1_funct3_d   = dec_funct3;
      s1_funct7_d   = dec_funct7;
      s1_ok_d       = dec_legal && dec_range_ok;
      s1_imm_word_d = dec_imm_word;
      s1_rd_d       = in_rd;
      s1_rs1_d      = in_rs1;
      s1_rs2_d      = in_rs2;
      s1_last_d     = in_last;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_instr_d = asm_word;
        s2_addr_d  = addr_cnt_q;
        s2_err_d   = !s1_ok_q;
        s2_last_d  = s1_last_q;
        // A program's last word restarts numbering for whatever follows it.
        addr_cnt_d = s1_last_q ? BASE_ADDR : addr_cnt_q + ADDR_W'(4);
      end
    end
  end

  // Stage-1 register.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q    <= 1'b0;
      s1_fmt_q      <= FmtR;
      s1_opcode_q   <= '0;
      s1_funct3_q   <= '0;
      s1_funct7_q   <= '0;
      s1_ok_q       <= 1'b0;
      s1_imm_word_q <= '0;
      s1_rd_q       <= '0;
      s1_rs1_q      <= '0;
      s1_rs2_q      <= '0;
      s1_last_q     <= 1'b0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_fmt_q      <= s1_fmt_d;
      s1_opcode_q   <= s1_opcode_d;
      s1_funct3_q   <= s1_funct3_d;
      s1_funct7_q   <= s1_funct7_d;
      s1_ok_q       <= s1_ok_d;
      s1_imm_word_q <= s1_imm_word_d;
      s1_rd_q       <= s1_rd_d;
      s1_rs1_q      <= s1_rs1_d;
      s1_rs2_q      <= s1_rs2_d;
      s1_last_q     <= s1_last_d;
    end
  end

  // Stage-2 output register and address counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      s2_valid_q <= 1'b0;
      s2_instr_q <= '0;
      s2_addr_q  <= BASE_ADDR;
      s2_err_q   <= 1'b0;
      s2_last_q  <= 1'b0;
      addr_cnt_q <= BASE_ADDR;
    end else begin
      s2_valid_q <= s2_valid_d;
      s2_instr_q <= s2_instr_d;
      s2_addr_q  <= s2_addr_d;
      s2_err_q   <= s2_err_d;
      s2_last_q  <= s2_last_d;
      addr_cnt_q <= addr_cnt_d;
    end
  end

endmodule
